// File: rtl/sopc_dbus_ctrl_pkg.sv
// Shared state encodings and types for the SOPC data-bus controller.
package sopc_dbus_ctrl_pkg;

  typedef logic [1:0] dbus_state_t;

  localparam logic [1:0] DBUS_IDLE = 2'd0;
  localparam logic [1:0] DBUS_REQ  = 2'd1;
  localparam logic [1:0] DBUS_DONE = 2'd2;
  localparam logic [1:0] DBUS_ERR  = 2'd3;

endpackage

// File: rtl/sopc_dbus_decode.sv
// Slave index decode: turns the top address bits into a one-hot strobe plus an in-range flag.
// Purely combinational; an index at or beyond NUM_SLV yields an all-zero one-hot and in_range_o=0.
module sopc_dbus_decode #(
  parameter int NUM_SLV = 4,
  parameter int IDX_W   = 2
) (
  input  logic [IDX_W-1:0]   idx_i,
  output logic [NUM_SLV-1:0] onehot_o,
  output logic               in_range_o
);

  always_comb begin
    onehot_o = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (idx_i == IDX_W'(k)) onehot_o[k] = 1'b1;
    end
  end

  assign in_range_o = |onehot_o;

endmodule

// File: rtl/sopc_dbus_ctrl.sv
// CPU data-bus controller: decode, per-access req/ack with slave wait states, timeout and unmapped errors.
// Ack in the first REQ cycle completes in 3 cycles; the CPU is stalled until the DONE/ERR cycle.
module sopc_dbus_ctrl
  import sopc_dbus_ctrl_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int NUM_SLV = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ce_i,
  input  logic                  cpu_we_i,
  input  logic [AW-1:0]         cpu_addr_i,
  input  logic [DW/8-1:0]       cpu_sel_i,
  input  logic [DW-1:0]         cpu_data_i,
  output logic [DW-1:0]         cpu_data_o,
  output logic                  cpu_stall_o,
  output logic                  bus_err_o,
  output logic [AW-1:0]         err_addr_o,
  output logic [NUM_SLV-1:0]    slv_ce_o,
  output logic                  slv_we_o,
  output logic [AW-1:0]         slv_addr_o,
  output logic [DW/8-1:0]       slv_sel_o,
  output logic [DW-1:0]         slv_data_o,
  input  logic [NUM_SLV*DW-1:0] slv_data_i,
  input  logic [NUM_SLV-1:0]    slv_ack_i
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  dbus_state_t          state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 we_q, we_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [DW-1:0]        wdat_q, wdat_d;
  logic [NUM_SLV-1:0]   onehot_q, onehot_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [AW-1:0]        err_addr_q, err_addr_d;

  logic [NUM_SLV-1:0]   dec_onehot;
  logic                 dec_hit;
  logic                 ack_hit;
  logic [DW-1:0]        sel_rdata;

  sopc_dbus_decode #(
    .NUM_SLV (NUM_SLV),
    .IDX_W   (IDX_W)
  ) u_decode (
    .idx_i      (cpu_addr_i[AW-1 -: IDX_W]),
    .onehot_o   (dec_onehot),
    .in_range_o (dec_hit)
  );

  // Only the latched slave's ack and data matter; everything else on the bus is ignored.
  assign ack_hit = |(slv_ack_i & onehot_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (onehot_q[k]) sel_rdata = sel_rdata | slv_data_i[k*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    onehot_d   = onehot_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_addr_d = err_addr_q;
    case (state_q)
      DBUS_IDLE: begin
        if (cpu_ce_i) begin
          addr_d   = cpu_addr_i;
          we_d     = cpu_we_i;
          sel_d    = cpu_sel_i;
          wdat_d   = cpu_data_i;
          onehot_d = dec_onehot;
          cnt_d    = '0;
          if (dec_hit) begin
            state_d = DBUS_REQ;
          end else begin
            rdata_d    = '0;
            err_addr_d = cpu_addr_i;
            state_d    = DBUS_ERR;
          end
        end
      end
      DBUS_REQ: begin
        // cnt_q counts wait cycles already spent; an ack in the limit cycle still wins.
        if (ack_hit) begin
          rdata_d = we_q ? '0 : sel_rdata;
          state_d = DBUS_DONE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rdata_d    = '0;
          err_addr_d = addr_q;
          state_d    = DBUS_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = DBUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DBUS_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      wdat_q     <= '0;
      onehot_q   <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      wdat_q     <= wdat_d;
      onehot_q   <= onehot_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Strobe is gated by the registered state so an async reset drops it immediately.
  assign slv_ce_o    = (state_q == DBUS_REQ) ? onehot_q : '0;
  assign slv_we_o    = we_q;
  assign slv_addr_o  = addr_q;
  assign slv_sel_o   = sel_q;
  assign slv_data_o  = wdat_q;
  assign cpu_data_o  = rdata_q;
  assign bus_err_o   = (state_q == DBUS_ERR);
  assign err_addr_o  = err_addr_q;
  assign cpu_stall_o = cpu_ce_i && (state_q != DBUS_DONE) && (state_q != DBUS_ERR);

endmodule

// File: tb/tb_sopc_dbus_ctrl.sv
// Bench for sopc_dbus_ctrl with three slaves so the top index is unmapped.
module tb_sopc_dbus_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 3;
  localparam int IW = 2;
  localparam int TO = 255;

  logic            clk;
  logic            rst;
  logic            cpu_ce_i;
  logic            cpu_we_i;
  logic [AW-1:0]   cpu_addr_i;
  logic [3:0]      cpu_sel_i;
  logic [DW-1:0]   cpu_data_i;
  logic [DW-1:0]   cpu_data_o;
  logic            cpu_stall_o;
  logic            bus_err_o;
  logic [AW-1:0]   err_addr_o;
  logic [NS-1:0]   slv_ce_o;
  logic            slv_we_o;
  logic [AW-1:0]   slv_addr_o;
  logic [3:0]      slv_sel_o;
  logic [DW-1:0]   slv_data_o;
  logic [NS*DW-1:0] slv_data_i;
  logic [NS-1:0]   slv_ack_i;

  logic [DW-1:0]   sdat [NS];
  logic [AW-1:0]   err_addr_m;
  int              total;
  int              bad;

  assign slv_data_i = {sdat[2], sdat[1], sdat[0]};

  sopc_dbus_ctrl #(
    .DW(DW), .AW(AW), .NUM_SLV(NS), .IDX_W(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .bus_err_o(bus_err_o), .err_addr_o(err_addr_o),
    .slv_ce_o(slv_ce_o), .slv_we_o(slv_we_o), .slv_addr_o(slv_addr_o),
    .slv_sel_o(slv_sel_o), .slv_data_o(slv_data_o), .slv_data_i(slv_data_i),
    .slv_ack_i(slv_ack_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    sel;
    logic [DW-1:0] wd;
    int            d;
    logic [NS-1:0] spur;
    int            e_stall;
    int            e_ce;
    logic          e_err;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the selected slave is strobed for (wait+1) cycles, capped at TIMEOUT+1 without ack;
  // the CPU stalls one cycle more (the IDLE decode cycle). Unmapped errors after one stall cycle.
  function automatic void model(input logic we, input logic [AW-1:0] addr, input int d,
                                output int e_stall, output int e_ce, output logic e_err,
                                output logic [DW-1:0] e_data);
    int idx;
    idx = int'(addr[AW-1 -: IW]);
    if (idx >= NS) begin
      e_ce = 0; e_stall = 1; e_err = 1'b1; e_data = '0;
    end else if (d <= TO) begin
      e_ce = d + 1; e_stall = d + 2; e_err = 1'b0; e_data = we ? '0 : sdat[idx];
    end else begin
      e_ce = TO + 1; e_stall = TO + 2; e_err = 1'b1; e_data = '0;
    end
  endfunction

  // Called at a negedge with the FSM idle; returns at a negedge with the FSM idle again.
  task automatic run_access(input string tag, input logic we, input logic [AW-1:0] addr,
                            input logic [3:0] sel, input logic [DW-1:0] wd, input int d,
                            input logic [NS-1:0] spur, input int e_stall, input int e_ce,
                            input logic e_err, input logic [DW-1:0] e_data);
    int n_stall, n_ce, idx;
    logic [NS-1:0] own;
    logic sig_ok, done, got_err;
    logic [DW-1:0] got_data;
    idx = int'(addr[AW-1 -: IW]);
    own = '0;
    if (idx < NS) own[idx] = 1'b1;
    n_stall = 0; n_ce = 0; sig_ok = 1'b1; done = 1'b0; got_err = 1'b0; got_data = '0;
    cpu_ce_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = wd;
    for (int cyc = 0; cyc < TO + 20 && !done; cyc++) begin
      #1;
      slv_ack_i = spur & ~own;
      if (cpu_stall_o) begin
        n_stall++;
        if (bus_err_o) sig_ok = 1'b0;
      end
      if (slv_ce_o != '0) begin
        if (slv_ce_o != own || slv_we_o != we || slv_addr_o != addr ||
            slv_sel_o != sel || slv_data_o != wd) sig_ok = 1'b0;
        if (n_ce == d) slv_ack_i = slv_ack_i | own;
        n_ce++;
      end
      if (!cpu_stall_o) begin
        done = 1'b1; got_err = bus_err_o; got_data = cpu_data_o;
      end
      @(negedge clk);
    end
    cpu_ce_i = 1'b0;
    slv_ack_i = '0;
    if (e_err) err_addr_m = addr;
    #1;
    chk({tag, " completed"}, 64'(done), 64'(1));
    chk({tag, " stall cycles"}, 64'(n_stall), 64'(e_stall));
    chk({tag, " strobe cycles"}, 64'(n_ce), 64'(e_ce));
    chk({tag, " bus_err"}, 64'(got_err), 64'(e_err));
    chk({tag, " cpu_data"}, 64'(got_data), 64'(e_data));
    chk({tag, " slave signals"}, 64'(sig_ok), 64'(1));
    chk({tag, " err pulse ends"}, 64'(bus_err_o), 64'(0));
    chk({tag, " err_addr"}, 64'(err_addr_o), 64'(err_addr_m));
    @(negedge clk);
  endtask

  initial begin
    int e_stall, e_ce, d, idx;
    logic e_err, we;
    logic [DW-1:0] e_data, wd;
    logic [AW-1:0] addr;
    logic [3:0] sel;
    logic [NS-1:0] spur;

    total = 0; bad = 0; err_addr_m = '0;
    rst = 1'b1; cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_sel_i = '0;
    cpu_data_i = '0; slv_ack_i = '0;
    sdat[0] = 32'h1234_5678; sdat[1] = 32'h9ABC_DEF0; sdat[2] = 32'h0BAD_F00D;

    vt[0] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         0,    3'b000,   2,   1, 1'b0, 32'h1234_5678};
    vt[1] = '{1'b1, 32'h4000_0004, 4'h3, 32'hAABB_CCDD, 5,    3'b000,   7,   6, 1'b0, 32'h0};
    vt[2] = '{1'b0, 32'h8000_0020, 4'hF, 32'h0,         1000, 3'b000, 257, 256, 1'b1, 32'h0};
    vt[3] = '{1'b0, 32'hC000_0000, 4'hF, 32'h0,         0,    3'b000,   1,   0, 1'b1, 32'h0};
    vt[4] = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         3,    3'b110,   5,   4, 1'b0, 32'h1234_5678};
    vt[5] = '{1'b0, 32'h8000_0000, 4'hF, 32'h0,         255,  3'b000, 257, 256, 1'b0, 32'h0BAD_F00D};
    vt[6] = '{1'b0, 32'h4000_0008, 4'hF, 32'h0,         256,  3'b011, 257, 256, 1'b1, 32'h0};
    vt[7] = '{1'b1, 32'h8000_000C, 4'h8, 32'h0000_0055, 1,    3'b011,   3,   2, 1'b0, 32'h0};

    #1;
    chk("reset stall follows ce", 64'(cpu_stall_o), 64'(1));
    chk("reset slv_ce", 64'(slv_ce_o), 64'(0));
    chk("reset cpu_data", 64'(cpu_data_o), 64'(0));
    chk("reset bus_err", 64'(bus_err_o), 64'(0));
    chk("reset err_addr", 64'(err_addr_o), 64'(0));
    chk("reset slv_addr", 64'(slv_addr_o), 64'(0));
    @(negedge clk);
    cpu_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_access($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].sel, vt[i].wd, vt[i].d,
                 vt[i].spur, vt[i].e_stall, vt[i].e_ce, vt[i].e_err, vt[i].e_data);
    end

    // Reset in the middle of a pending request.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h4000_0000; cpu_sel_i = 4'hF;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-reset strobe", 64'(slv_ce_o), 64'(3'b010));
    rst = 1'b1;
    #1;
    chk("mid-req reset strobe", 64'(slv_ce_o), 64'(0));
    chk("mid-req reset err_addr", 64'(err_addr_o), 64'(0));
    chk("mid-req reset stall", 64'(cpu_stall_o), 64'(1));
    err_addr_m = '0;
    @(negedge clk);
    rst = 1'b0; cpu_ce_i = 1'b0;
    @(negedge clk);
    run_access("after reset", 1'b0, 32'h4000_0010, 4'hF, 32'h0, 2, 3'b000, 4, 3, 1'b0, sdat[1]);

    // CPU withdraws ce mid-request: slave still finishes, stall drops at once.
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h8000_0040; cpu_sel_i = 4'hF;
    @(negedge clk);
    @(negedge clk);
    cpu_ce_i = 1'b0;
    #1;
    chk("flush stall", 64'(cpu_stall_o), 64'(0));
    chk("flush strobe held", 64'(slv_ce_o), 64'(3'b100));
    slv_ack_i = 3'b100;
    @(negedge clk);
    slv_ack_i = '0;
    #1;
    chk("flush strobe drop", 64'(slv_ce_o), 64'(0));
    chk("flush data", 64'(cpu_data_o), 64'(sdat[2]));
    chk("flush no err", 64'(bus_err_o), 64'(0));
    @(negedge clk);

    for (int n = 0; n < 30; n++) begin
      idx = int'($urandom_range(0, 3));
      addr = $urandom;
      addr[AW-1 -: IW] = IW'(idx);
      we = 1'($urandom);
      sel = 4'($urandom);
      wd = $urandom;
      spur = NS'($urandom);
      for (int k = 0; k < NS; k++) sdat[k] = $urandom;
      if ($urandom_range(0, 9) == 0) d = TO + int'($urandom_range(0, 1));
      else d = int'($urandom_range(0, 6));
      model(we, addr, d, e_stall, e_ce, e_err, e_data);
      run_access($sformatf("rand%0d", n), we, addr, sel, wd, d, spur, e_stall, e_ce, e_err, e_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
